lcd_cmd_driver: RTL and testbench
=================================

Name: lcd_cmd_driver

Overview:
- Consumer end of the 9-bit LCD command stream (bit 8 = RS, bits 7:0 = ASCII code or control code).
- Accepts one command at a time over a valid/ready handshake.
- Drives the HD44780-style parallel pins (RS, RW, E, DB[7:0]) with the required setup, enable-pulse, hold and execution-wait timing.
- Sits between the command sequencer and the board LCD pins.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency; cycles per microsecond = CLK_FREQ_HZ/1_000_000.
- SETUP_CYC, 2, cycles RS/DB are stable before E rises.
- E_PULSE_CYC, 12, cycles E is held high.
- HOLD_CYC, 2, cycles RS/DB are held after E falls.
- SHORT_WAIT_US, 40, execution wait for normal commands and character writes.
- LONG_WAIT_US, 1600, execution wait for Clear Display and Return Home.
- POWERUP_US, 40000, power-on delay (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_i  in  9  command: {RS, code}.
- cmd_valid_i  in  1  cmd_i is valid.
- cmd_ready_o  out  1  driver can accept a command.
- busy_o  out  1  a command or the init sequence is in progress.
- init_done_o  out  1  power-on initialisation complete.
- lcd_rs_o  out  1  LCD register select.
- lcd_rw_o  out  1  LCD read/write; always 0 (write only).
- lcd_en_o  out  1  LCD enable strobe.
- lcd_data_o  out  8  LCD data bus.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - lcd_rs_o=0, lcd_rw_o=0, lcd_en_o=0, lcd_data_o=8'h00.
  - busy_o=0, cmd_ready_o=1, init_done_o=1 (macro off).
  - Asserting reset mid-command forces IDLE and drops E in the same instant.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT (plus INIT_DELAY and INIT_ISSUE when the macro is on).
- IDLE:
  - cmd_ready_o=1 and busy_o=0.
  - On cmd_valid_i && cmd_ready_o, latch cmd_i into an internal register.
  - Drive lcd_rs_o=cmd[8] and lcd_data_o=cmd[7:0] from the next edge, then go to SETUP.
- SETUP: E=0 for SETUP_CYC cycles, then PULSE.
- PULSE: E=1 for E_PULSE_CYC cycles, then HOLD.
- HOLD: E=0 with RS/DB unchanged for HOLD_CYC cycles, then WAIT.
- WAIT:
  - E=0; count the wait cycles, then return to IDLE.
  - Long wait = LONG_WAIT_US·cycles/us, used when RS=0 and code is 8'h01 or in 8'h02..8'h03.
  - Short wait = SHORT_WAIT_US·cycles/us otherwise, including code 8'h00.
- Outside IDLE: cmd_ready_o=0 and busy_o=1.
- Latency: cmd_ready_o falls on the edge after the handshake. It returns exactly SETUP_CYC+E_PULSE_CYC+HOLD_CYC+wait cycles later.
- Command spacing: at most one command per busy period plus one IDLE cycle; there is no back-to-back acceptance.
- Input stability: cmd_i and cmd_valid_i changes while busy are ignored, and the latched command is never disturbed. A valid held through busy is accepted on the first IDLE cycle.
- lcd_rs_o and lcd_data_o hold the last command after completion (not cleared).
- Counter:
  - Single down-counter sized $clog2 of the largest wait in cycles, saturating at 0.
  - Reloaded on each state entry.
  - A phase count of 0 is treated as 1 cycle.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- Without it: init_done_o is tied 1 and the driver is ready right after reset.
- With it, after reset:
  - init_done_o=0, cmd_ready_o=0, busy_o=1.
  - Wait POWERUP_US in INIT_DELAY.
  - Then issue internally, through the same SETUP/PULSE/HOLD/WAIT path: 9'h038 (8-bit, 2-line), 9'h00C (display on), 9'h001 (clear, long wait), 9'h006 (entry right).
  - After the last WAIT, init_done_o rises and the FSM enters IDLE.
  - External commands are never accepted before init_done_o=1.

Decomposition:
- Package lcd_drv_pkg:
  - state enum typedef.
  - LCD_CMD_W=9.
  - Init command ROM constants (9'h038, 9'h00C, 9'h001, 9'h006).
  - Function is_long_cmd(logic [8:0]).
  - Function us_to_cyc(int us).
- One natural sub-module: lcd_delay_cnt (loadable down-counter with done flag), reused for every phase.

Test Plan:
- Bench uses CLK_FREQ_HZ=1_000_000 (1 cycle/us), SHORT=40, LONG=1600.
- Character write: send 9'h141 ('A') -> lcd_rs_o=1, lcd_data_o=8'h41, E high for exactly 12 cycles starting 2 cycles after latch; cmd_ready_o low for 2+12+2+40=56 cycles.
- Clear: send 9'h001 -> lcd_rs_o=0, lcd_data_o=8'h01; ready low for 2+12+2+1600=1616 cycles.
- Busy input: hold cmd_valid_i=1 with 9'h142, then change cmd_i to 9'h143 mid-command -> first command's DB stays 8'h42 through HOLD; the second command accepted is 9'h143, on the first IDLE cycle.
- Reset mid-PULSE: drop rst_n while E=1 -> E, RS and DB go to 0 asynchronously; after release, cmd_ready_o=1 on the first edge (macro off).
- Init sequence: with LCD_INIT_SEQ_EN and POWERUP_US=100, ready stays low through:
  - 100 cycles of power-up delay;
  - E pulses carrying DB=8'h38, 8'h0C, 8'h01, 8'h06 in order;
  - then init_done_o=1, cmd_ready_o=1.
- Code 9'h000 (RS=0, code 0) -> short wait, 56 busy cycles.

Source files
------------

// File: rtl/lcd_drv_pkg.sv
// Shared types, init command ROM and timing helpers for the HD44780-style LCD command driver.
package lcd_drv_pkg;

  localparam int LCD_CMD_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    INIT_DELAY,
    INIT_ISSUE
  } state_e;

  localparam logic [LCD_CMD_W-1:0] INIT_FUNC_SET   = 9'h038;
  localparam logic [LCD_CMD_W-1:0] INIT_DISP_ON    = 9'h00C;
  localparam logic [LCD_CMD_W-1:0] INIT_CLEAR      = 9'h001;
  localparam logic [LCD_CMD_W-1:0] INIT_ENTRY_MODE = 9'h006;

  // Entry 0 is issued first.
  localparam logic [3:0][LCD_CMD_W-1:0] INIT_ROM =
    {INIT_ENTRY_MODE, INIT_CLEAR, INIT_DISP_ON, INIT_FUNC_SET};

  // Clear Display (01) and Return Home (02/03) need the long execution time.
  function automatic logic is_long_cmd(input logic [LCD_CMD_W-1:0] cmd);
    return !cmd[8] && (cmd[7:0] == 8'h01 || cmd[7:0] == 8'h02 || cmd[7:0] == 8'h03);
  endfunction

  function automatic int unsigned us_to_cyc(input int unsigned us,
                                            input int unsigned clk_hz = 50_000_000);
    return us * (clk_hz / 1_000_000);
  endfunction

  // Counter reload value so that a phase lasts n cycles; n == 0 still lasts one.
  function automatic int unsigned phase_load(input int unsigned n);
    return (n == 0) ? 0 : n - 1;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable saturating down-counter; done_o is high while the count is zero.
module lcd_delay_cnt #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_cmd_driver.sv
// HD44780 parallel-bus command driver: one command per handshake, setup/E-pulse/hold/exec-wait timing.
// Optional power-on init sequence enabled with `define LCD_INIT_SEQ_EN.
module lcd_cmd_driver
  import lcd_drv_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned E_PULSE_CYC   = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned SHORT_WAIT_US = 40,
  parameter int unsigned LONG_WAIT_US  = 1600
`ifdef LCD_INIT_SEQ_EN
  ,
  parameter int unsigned POWERUP_US    = 40000
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LCD_CMD_W-1:0] cmd_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  output logic                 busy_o,
  output logic                 init_done_o,
  output logic                 lcd_rs_o,
  output logic                 lcd_rw_o,
  output logic                 lcd_en_o,
  output logic [7:0]           lcd_data_o
);

  localparam int unsigned SHORT_CYC = us_to_cyc(SHORT_WAIT_US, CLK_FREQ_HZ);
  localparam int unsigned LONG_CYC  = us_to_cyc(LONG_WAIT_US, CLK_FREQ_HZ);
`ifdef LCD_INIT_SEQ_EN
  localparam int unsigned PWR_CYC   = us_to_cyc(POWERUP_US, CLK_FREQ_HZ);
`else
  localparam int unsigned PWR_CYC   = 0;
`endif
  localparam int unsigned MAX_CYC = max2(max2(max2(LONG_CYC, SHORT_CYC), PWR_CYC),
                                         max2(max2(SETUP_CYC, E_PULSE_CYC), HOLD_CYC));
  localparam int unsigned CW = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(phase_load(SETUP_CYC));
  localparam logic [CW-1:0] PULSE_LD = CW'(phase_load(E_PULSE_CYC));
  localparam logic [CW-1:0] HOLD_LD  = CW'(phase_load(HOLD_CYC));
  localparam logic [CW-1:0] SHORT_LD = CW'(phase_load(SHORT_CYC));
  localparam logic [CW-1:0] LONG_LD  = CW'(phase_load(LONG_CYC));
  localparam logic [CW-1:0] PWR_LD   = CW'(phase_load(PWR_CYC));

  state_e                 state_q, state_d;
  logic [LCD_CMD_W-1:0]   cmd_q, cmd_d;
  logic                   en_q, en_d;
  logic                   cnt_load;
  logic [CW-1:0]          cnt_load_val;
  logic                   cnt_done;
  logic                   cmd_ready;
  logic [CW-1:0]          wait_ld;

`ifdef LCD_INIT_SEQ_EN
  localparam state_e RST_STATE = INIT_DELAY;
  logic       init_done_q, init_done_d;
  logic [1:0] idx_q, idx_d;
  assign cmd_ready   = (state_q == IDLE) && init_done_q;
  assign init_done_o = init_done_q;
`else
  localparam state_e RST_STATE = IDLE;
  assign cmd_ready   = (state_q == IDLE);
  assign init_done_o = 1'b1;
`endif

  assign wait_ld = is_long_cmd(cmd_q) ? LONG_LD : SHORT_LD;

  lcd_delay_cnt #(
    .W       (CW),
    .RST_VAL (PWR_LD)
  ) u_delay_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    en_d         = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
`ifdef LCD_INIT_SEQ_EN
    init_done_d  = init_done_q;
    idx_d        = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready) begin
          cmd_d        = cmd_i;
          state_d      = SETUP;
          cnt_load     = 1'b1;
          cnt_load_val = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_d      = PULSE;
          en_d         = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LD;
        end
      end
      PULSE: begin
        en_d = 1'b1;
        if (cnt_done) begin
          state_d      = HOLD;
          en_d         = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d      = WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = wait_ld;
        end
      end
      WAIT: begin
        if (cnt_done) begin
          state_d = IDLE;
`ifdef LCD_INIT_SEQ_EN
          if (!init_done_q) begin
            if (idx_q == 2'd3) begin
              init_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = INIT_ISSUE;
            end
          end
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      INIT_DELAY: begin
        if (cnt_done) begin
          state_d = INIT_ISSUE;
        end
      end
      INIT_ISSUE: begin
        cmd_d        = INIT_ROM[idx_q];
        state_d      = SETUP;
        cnt_load     = 1'b1;
        cnt_load_val = SETUP_LD;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      cmd_q       <= '0;
      en_q        <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      init_done_q <= 1'b0;
      idx_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      en_q        <= en_d;
`ifdef LCD_INIT_SEQ_EN
      init_done_q <= init_done_d;
      idx_q       <= idx_d;
`endif
    end
  end

  assign cmd_ready_o = cmd_ready;
  assign busy_o      = (state_q != IDLE);
  assign lcd_rs_o    = cmd_q[8];
  assign lcd_data_o  = cmd_q[7:0];
  assign lcd_en_o    = en_q;
  assign lcd_rw_o    = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Directed bench for lcd_cmd_driver at 1 cycle/us: timing, wait selection, busy-input and reset behaviour.
module tb_lcd_cmd_driver;

  logic       clk;
  logic       rst_n;
  logic [8:0] cmd_i;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic       busy_o;
  logic       init_done_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_en_o;
  logic [7:0] lcd_data_o;

  int n_cmp = 0;
  int n_err = 0;

  lcd_cmd_driver #(
    .CLK_FREQ_HZ (1_000_000)
`ifdef LCD_INIT_SEQ_EN
    , .POWERUP_US (100)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_i       (cmd_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .busy_o      (busy_o),
    .init_done_o (init_done_o),
    .lcd_rs_o    (lcd_rs_o),
    .lcd_rw_o    (lcd_rw_o),
    .lcd_en_o    (lcd_en_o),
    .lcd_data_o  (lcd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Send one command, then sample each busy cycle on the falling edge until ready returns.
  task automatic run_cmd(input logic [8:0] c, output int low, output int en_cnt,
                         output int en_first, output bit stable);
    @(negedge clk);
    cmd_i       = c;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    low = 0; en_cnt = 0; en_first = -1; stable = 1'b1;
    while (!cmd_ready_o && low < 4000) begin
      if (lcd_en_o) begin
        if (en_first < 0) en_first = low;
        en_cnt++;
      end
      if (lcd_data_o !== c[7:0] || lcd_rs_o !== c[8] || lcd_rw_o !== 1'b0 || busy_o !== 1'b1)
        stable = 1'b0;
      low++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_i = '0; cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o} !== 11'h000) begin
      n_err++; $display("FAIL reset_pins: got %h want 000", {lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o});
    end
`ifdef LCD_INIT_SEQ_EN
    n_cmp++;
    if ({busy_o, cmd_ready_o, init_done_o} !== 3'b100) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 100", {busy_o, cmd_ready_o, init_done_o});
    end
`else
    n_cmp++;
    if ({busy_o, cmd_ready_o, init_done_o} !== 3'b011) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 011", {busy_o, cmd_ready_o, init_done_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready_o);
    end
`endif
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic test_init();
    int low = 0;
    int pulses = 0;
    bit prev_en = 1'b0;
    bit done_early = 1'b0;
    logic [7:0] seen [4];
    logic [7:0] exp_db [4];
    exp_db[0] = 8'h38; exp_db[1] = 8'h0C; exp_db[2] = 8'h01; exp_db[3] = 8'h06;
    for (int i = 0; i < 4; i++) seen[i] = 8'hxx;
    cmd_i = 9'h150; cmd_valid_i = 1'b1;
    rst_n = 1'b1;
    // 99 sampled delay cycles + 4 x (issue + 2 + 12 + 2) + 40 + 40 + 1600 + 40
    do begin
      @(negedge clk);
      if (!cmd_ready_o) begin
        low++;
        if (init_done_o) done_early = 1'b1;
        if (lcd_en_o && !prev_en) begin
          if (pulses < 4) seen[pulses] = lcd_data_o;
          pulses++;
        end
        prev_en = lcd_en_o;
      end
    end while (!cmd_ready_o && low < 5000);
    n_cmp++;
    if (low !== 1887) begin n_err++; $display("FAIL init_ready_low: got %0d want 1887", low); end
    n_cmp++;
    if (pulses !== 4) begin n_err++; $display("FAIL init_pulse_count: got %0d want 4", pulses); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (seen[i] !== exp_db[i]) begin
        n_err++; $display("FAIL init_db_%0d: got %h want %h", i, seen[i], exp_db[i]);
      end
    end
    n_cmp++;
    if (done_early || init_done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL init_done: got early=%b done=%b busy=%b want 0 1 0", done_early, init_done_o, busy_o);
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (cmd_ready_o !== 1'b0 || {lcd_rs_o, lcd_data_o} !== 9'h150) begin
      n_err++; $display("FAIL init_first_accept: got rdy=%b cmd=%h want 0 150", cmd_ready_o, {lcd_rs_o, lcd_data_o});
    end
    for (int i = 0; i < 100 && !cmd_ready_o; i++) @(negedge clk);
  endtask
`endif

  task automatic test_char_write();
    int low, en_cnt, en_first; bit stable;
    run_cmd(9'h141, low, en_cnt, en_first, stable);
    n_cmp++;
    if (low !== 56) begin n_err++; $display("FAIL char_ready_low: got %0d want 56", low); end
    n_cmp++;
    if (en_cnt !== 12 || en_first !== 2) begin
      n_err++; $display("FAIL char_e_pulse: got len=%0d start=%0d want 12 2", en_cnt, en_first);
    end
    n_cmp++;
    if (!stable) begin n_err++; $display("FAIL char_bus_stable: got 0 want 1"); end
    n_cmp++;
    if ({lcd_rs_o, lcd_data_o} !== 9'h141 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL char_hold_after: got %h busy=%b want 141 0", {lcd_rs_o, lcd_data_o}, busy_o);
    end
  endtask

  task automatic test_wait_select();
    logic [8:0] cmds [6];
    int exp_low [6];
    int low, en_cnt, en_first; bit stable;
    cmds[0] = 9'h001; exp_low[0] = 1616;
    cmds[1] = 9'h000; exp_low[1] = 56;
    cmds[2] = 9'h002; exp_low[2] = 1616;
    cmds[3] = 9'h003; exp_low[3] = 1616;
    cmds[4] = 9'h004; exp_low[4] = 56;
    cmds[5] = 9'h101; exp_low[5] = 56;
    for (int i = 0; i < 6; i++) begin
      run_cmd(cmds[i], low, en_cnt, en_first, stable);
      n_cmp++;
      if (low !== exp_low[i] || en_cnt !== 12 || !stable) begin
        n_err++;
        $display("FAIL wait_%h: got low=%0d e=%0d stable=%b want %0d 12 1", cmds[i], low, en_cnt, stable, exp_low[i]);
      end
    end
  endtask

  task automatic test_busy_input();
    int low = 0;
    bit stable = 1'b1;
    @(negedge clk);
    cmd_i = 9'h142; cmd_valid_i = 1'b1;
    @(negedge clk);
    while (!cmd_ready_o && low < 200) begin
      if (low == 5) cmd_i = 9'h143;
      if ({lcd_rs_o, lcd_data_o} !== 9'h142) stable = 1'b0;
      low++;
      @(negedge clk);
    end
    n_cmp++;
    if (!stable || low !== 56) begin
      n_err++; $display("FAIL busy_first_cmd: got stable=%b low=%0d want 1 56", stable, low);
    end
    n_cmp++;
    if ({lcd_rs_o, lcd_data_o} !== 9'h142) begin
      n_err++; $display("FAIL busy_idle_hold: got %h want 142", {lcd_rs_o, lcd_data_o});
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    n_cmp++;
    if (cmd_ready_o !== 1'b0 || {lcd_rs_o, lcd_data_o} !== 9'h143) begin
      n_err++; $display("FAIL busy_second_accept: got rdy=%b cmd=%h want 0 143", cmd_ready_o, {lcd_rs_o, lcd_data_o});
    end
    for (int i = 0; i < 100 && !cmd_ready_o; i++) @(negedge clk);
  endtask

  task automatic test_reset_mid_pulse();
    int t = 0;
    @(negedge clk);
    cmd_i = 9'h155; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    while (!lcd_en_o && t < 20) begin t++; @(negedge clk); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (lcd_en_o !== 1'b1) begin n_err++; $display("FAIL rst_mid_reach_pulse: got %b want 1", lcd_en_o); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({lcd_en_o, lcd_rs_o, lcd_data_o} !== 10'h000) begin
      n_err++; $display("FAIL rst_mid_async: got %h want 000", {lcd_en_o, lcd_rs_o, lcd_data_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef LCD_INIT_SEQ_EN
    n_cmp++;
    if (cmd_ready_o !== 1'b0 || init_done_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_release: got rdy=%b done=%b want 0 0", cmd_ready_o, init_done_o);
    end
`else
    n_cmp++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_release: got rdy=%b busy=%b want 1 0", cmd_ready_o, busy_o);
    end
`endif
  endtask

  initial begin
    test_reset();
`ifdef LCD_INIT_SEQ_EN
    test_init();
`endif
    test_char_write();
    test_wait_select();
    test_busy_input();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
